// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one operand-stack memory port between
// the instruction control unit (port 0) and the frame/local-variable unit
// (port 1). Tracks occupancy and rejects overflow/underflow locally.
// Optional feature macro: STACK_ARB_TIMEOUT_EN (abandon a downstream op that
// has not completed after TIMEOUT wait cycles).
module stack_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_trigger,
  input  logic                         req0_push,
  input  logic [WIDTH-1:0]             req0_wdata,
  output logic [WIDTH-1:0]             req0_rdata,
  output logic                         req0_done,
  output logic                         req0_err,
  input  logic                         req1_trigger,
  input  logic                         req1_push,
  input  logic [WIDTH-1:0]             req1_wdata,
  output logic [WIDTH-1:0]             req1_rdata,
  output logic                         req1_done,
  output logic                         req1_err,
  output logic                         stk_trigger,
  output logic                         stk_push,
  output logic [WIDTH-1:0]             stk_wdata,
  input  logic [WIDTH-1:0]             stk_rdata,
  input  logic                         stk_done,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  // Elaboration guards on parameter ranges
  if (DEPTH < 1) begin : g_bad_depth
    $error("stack_arbiter: DEPTH must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("stack_arbiter: TIMEOUT must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       push_q, push_d;
  logic [WIDTH-1:0] wdata0_q, wdata0_d;
  logic [WIDTH-1:0] wdata1_q, wdata1_d;
  logic             last_q, last_d;
  logic             cur_q, cur_d;
  logic             stk_trigger_d;
  logic             stk_push_d;
  logic [WIDTH-1:0] stk_wdata_d;
  logic [1:0]       done_d;
  logic [1:0]       err_d;
  logic [WIDTH-1:0] rdata0_d, rdata1_d;
  logic [DW-1:0]    depth_d;
  logic             gnt_c;
  logic             sel_push_c;
  logic [WIDTH-1:0] sel_wdata_c;

`ifdef STACK_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, capture, grant and completion logic
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    push_d        = push_q;
    wdata0_d      = wdata0_q;
    wdata1_d      = wdata1_q;
    last_d        = last_q;
    cur_d         = cur_q;
    stk_trigger_d = 1'b0;
    stk_push_d    = stk_push;
    stk_wdata_d   = stk_wdata;
    done_d        = 2'b00;
    err_d         = 2'b00;
    rdata0_d      = req0_rdata;
    rdata1_d      = req1_rdata;
    depth_d       = depth;
    gnt_c         = 1'b0;
    sel_push_c    = 1'b0;
    sel_wdata_c   = '0;
`ifdef STACK_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    // A trigger on an already-pending port is a protocol violation and dropped
    if (req0_trigger && !pending_q[0]) begin
      pending_d[0] = 1'b1;
      push_d[0]    = req0_push;
      wdata0_d     = req0_wdata;
    end
    if (req1_trigger && !pending_q[1]) begin
      pending_d[1] = 1'b1;
      push_d[1]    = req1_push;
      wdata1_d     = req1_wdata;
    end

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          gnt_c       = (&pending_q) ? ~last_q : pending_q[1];
          sel_push_c  = gnt_c ? push_q[1] : push_q[0];
          sel_wdata_c = gnt_c ? wdata1_q : wdata0_q;
          last_d      = gnt_c;
          cur_d       = gnt_c;
          if ((!sel_push_c && depth == '0) ||
              ( sel_push_c && depth == DW'(DEPTH))) begin
            // Reject locally: memory is never touched
            pending_d[gnt_c] = 1'b0;
            done_d[gnt_c]    = 1'b1;
            err_d[gnt_c]     = 1'b1;
          end else begin
            stk_trigger_d = 1'b1;
            stk_push_d    = sel_push_c;
            stk_wdata_d   = sel_wdata_c;
            state_d       = WAIT;
`ifdef STACK_ARB_TIMEOUT_EN
            cnt_d         = '0;
`endif
          end
        end
      end

      WAIT: begin
        if (stk_done) begin
          if (stk_push) begin
            depth_d = depth + DW'(1);
          end else begin
            depth_d = depth - DW'(1);
            if (cur_q) rdata1_d = stk_rdata;
            else       rdata0_d = stk_rdata;
          end
          pending_d[cur_q] = 1'b0;
          done_d[cur_q]    = 1'b1;
          state_d          = IDLE;
        end
`ifdef STACK_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Give up on the downstream op; occupancy and read data untouched
          pending_d[cur_q] = 1'b0;
          done_d[cur_q]    = 1'b1;
          err_d[cur_q]     = 1'b1;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 2'b00;
      push_q      <= 2'b00;
      wdata0_q    <= '0;
      wdata1_q    <= '0;
      last_q      <= 1'b1;
      cur_q       <= 1'b0;
      stk_trigger <= 1'b0;
      stk_push    <= 1'b0;
      stk_wdata   <= '0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      req0_err    <= 1'b0;
      req1_err    <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
      depth       <= '0;
`ifdef STACK_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      pending_q   <= pending_d;
      push_q      <= push_d;
      wdata0_q    <= wdata0_d;
      wdata1_q    <= wdata1_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      stk_trigger <= stk_trigger_d;
      stk_push    <= stk_push_d;
      stk_wdata   <= stk_wdata_d;
      req0_done   <= done_d[0];
      req1_done   <= done_d[1];
      req0_err    <= err_d[0];
      req1_err    <= err_d[1];
      req0_rdata  <= rdata0_d;
      req1_rdata  <= rdata1_d;
      depth       <= depth_d;
`ifdef STACK_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: scoreboard bench for stack_arbiter with a stub stack
// memory and a reference model of occupancy, arbitration and read data.
module tb_stack_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
`ifdef STACK_ARB_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 8;
`else
  localparam int unsigned TIMEOUT = 64;
`endif
  localparam int unsigned DW      = $clog2(DEPTH + 1);
  localparam int          MEM_LAT = 3;
  localparam int          BUDGET  = 60;

  logic             clk, rst;
  logic             req0_trigger, req0_push, req0_done, req0_err;
  logic             req1_trigger, req1_push, req1_done, req1_err;
  logic [WIDTH-1:0] req0_wdata, req0_rdata, req1_wdata, req1_rdata;
  logic             stk_trigger, stk_push, stk_done;
  logic [WIDTH-1:0] stk_wdata, stk_rdata;
  logic [DW-1:0]    depth;

  stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_trigger(req0_trigger), .req0_push(req0_push), .req0_wdata(req0_wdata),
    .req0_rdata(req0_rdata), .req0_done(req0_done), .req0_err(req0_err),
    .req1_trigger(req1_trigger), .req1_push(req1_push), .req1_wdata(req1_wdata),
    .req1_rdata(req1_rdata), .req1_done(req1_done), .req1_err(req1_err),
    .stk_trigger(stk_trigger), .stk_push(stk_push), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_done(stk_done), .depth(depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] rdata;
    logic [DW-1:0]    depth;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Scoreboards and reference model
  exp_t             sb0[$];
  exp_t             sb1[$];
  logic [WIDTH-1:0] m_stk[$];
  logic [WIDTH-1:0] exp_log[$];
  logic [WIDTH-1:0] m_rd[2];
  int               m_depth;
  int               m_last;
  logic             to_mode;

  // Stub memory state
  logic [WIDTH-1:0] mem[$];
  logic [WIDTH-1:0] mem_log[$];
  logic [WIDTH-1:0] mem_rd;
  logic             mem_on;
  int               mem_cnt;
  int               trig_cnt, trig_cyc, sd_cyc, e0;
  logic             last_push;
  logic [WIDTH-1:0] last_wdata;
  int               done_cyc[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Predict the completion of one granted request, in service order
  task automatic expect_op(input int p, input logic push, input logic [WIDTH-1:0] d);
    exp_t e;
    logic err;
    err = to_mode ? 1'b1 : (push ? (m_depth == int'(DEPTH)) : (m_depth == 0));
    if (!err) begin
      if (push) begin
        m_stk.push_back(d);
        exp_log.push_back(d);
        m_depth++;
      end else begin
        m_rd[p] = m_stk.pop_back();
        m_depth--;
      end
    end
    e.err   = err;
    e.rdata = m_rd[p];
    e.depth = DW'(m_depth);
    if (p == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    m_last = p;
  endtask

  // Output monitor and stub memory, evaluated at each falling edge
  task automatic mon();
    stk_done = 1'b0;
    if (req0_done && req1_done) chk("done_excl", 64'(1), 64'(0));
    for (int p = 0; p < 2; p++) begin
      logic dn, er;
      logic [WIDTH-1:0] rd;
      exp_t e;
      int sz;
      dn = (p == 0) ? req0_done : req1_done;
      er = (p == 0) ? req0_err  : req1_err;
      rd = (p == 0) ? req0_rdata : req1_rdata;
      sz = (p == 0) ? sb0.size() : sb1.size();
      if (dn) begin
        done_cyc[p] = cyc;
        if (sz == 0) begin
          chk($sformatf("unexp_done%0d", p), 64'(1), 64'(0));
        end else begin
          if (p == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          chk($sformatf("err%0d", p), 64'(er), 64'(e.err));
          chk($sformatf("rdata%0d", p), 64'(rd), 64'(e.rdata));
          chk($sformatf("depth%0d", p), 64'(depth), 64'(e.depth));
        end
      end else if (er) begin
        chk($sformatf("err_nodone%0d", p), 64'(1), 64'(0));
      end
    end
    if (stk_trigger) begin
      trig_cnt++;
      trig_cyc   = cyc;
      last_push  = stk_push;
      last_wdata = stk_wdata;
      if (stk_push) begin
        mem.push_back(stk_wdata);
        mem_log.push_back(stk_wdata);
      end else if (mem.size() > 0) begin
        mem_rd = mem.pop_back();
      end else begin
        mem_rd = '0;
      end
      if (mem_on) mem_cnt = MEM_LAT;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        chk("hold_push", 64'(stk_push), 64'(last_push));
        chk("hold_wdata", 64'(stk_wdata), 64'(last_wdata));
        stk_done  = 1'b1;
        stk_rdata = mem_rd;
        sd_cyc    = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb0.delete(); sb1.delete(); m_stk.delete(); exp_log.delete();
    mem.delete(); mem_log.delete();
    mem_cnt = 0; stk_done = 1'b0; to_mode = 1'b0;
    m_depth = 0; m_rd[0] = '0; m_rd[1] = '0; m_last = 1;
  endtask

  task automatic req(input int p, input logic push, input logic [WIDTH-1:0] d);
    if (p == 0) begin req0_trigger = 1'b1; req0_push = push; req0_wdata = d; end
    else        begin req1_trigger = 1'b1; req1_push = push; req1_wdata = d; end
    expect_op(p, push, d);
    tick();
    req0_trigger = 1'b0;
    req1_trigger = 1'b0;
    e0 = cyc;
  endtask

  task automatic req2(input logic p0, input logic [WIDTH-1:0] d0,
                      input logic p1, input logic [WIDTH-1:0] d1);
    int first;
    req0_trigger = 1'b1; req0_push = p0; req0_wdata = d0;
    req1_trigger = 1'b1; req1_push = p1; req1_wdata = d1;
    first = (m_last == 1) ? 0 : 1;
    if (first == 0) begin expect_op(0, p0, d0); expect_op(1, p1, d1); end
    else            begin expect_op(1, p1, d1); expect_op(0, p0, d0); end
    tick();
    req0_trigger = 1'b0;
    req1_trigger = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < BUDGET && (sb0.size() + sb1.size()) > 0; i++) tick();
    chk("drain", 64'(sb0.size() + sb1.size()), 64'(0));
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    req0_trigger = 1'b0; req0_push = 1'b0; req0_wdata = '0;
    req1_trigger = 1'b0; req1_push = 1'b0; req1_wdata = '0;
    stk_done = 1'b0; stk_rdata = '0;
    mem_on = 1'b1; mem_cnt = 0; trig_cnt = 0; trig_cyc = 0; sd_cyc = 0; e0 = 0;
    last_push = 1'b0; last_wdata = '0; mem_rd = '0;
    done_cyc[0] = 0; done_cyc[1] = 0;
    do_reset();

    // Reset values
    chk("rst_depth", 64'(depth), 64'(0));
    chk("rst_done", 64'({req0_done, req1_done, req0_err, req1_err}), 64'(0));
    chk("rst_stk", 64'({stk_trigger, stk_push, stk_wdata}), 64'(0));
    chk("rst_rdata", {req0_rdata, req1_rdata}, 64'(0));

    // Pop on empty stack is rejected without touching memory
    t0 = trig_cnt;
    req(1, 1'b0, '0);
    wait_idle();
    chk("rej_notrig", 64'(trig_cnt - t0), 64'(0));
    chk("rej_lat", 64'(done_cyc[1] - e0), 64'(1));
    chk("rej_depth", 64'(depth), 64'(0));

    // Single push with a stray re-trigger while pending
    t0 = trig_cnt;
    req(0, 1'b1, 32'h0000_002A);
    req0_trigger = 1'b1; req0_push = 1'b0; req0_wdata = 32'hDEAD_BEEF;
    tick();
    req0_trigger = 1'b0;
    wait_idle();
    repeat (8) tick();
    chk("push_trigs", 64'(trig_cnt - t0), 64'(1));
    chk("push_dir", 64'(last_push), 64'(1));
    chk("push_wdata", 64'(last_wdata), 64'(32'h2A));
    chk("lat_trig", 64'(trig_cyc - e0), 64'(1));
    chk("lat_done", 64'(done_cyc[0] - sd_cyc), 64'(1));
    chk("push_depth", 64'(depth), 64'(1));

    // Simultaneous pushes, then simultaneous pops
    do_reset();
    req2(1'b1, 32'h11, 1'b1, 32'h22);
    wait_idle();
    chk("tie_log_n", 64'(mem_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < mem_log.size(); i++)
      chk($sformatf("tie_log%0d", i), 64'(mem_log[i]), 64'(exp_log[i]));
    chk("tie_depth", 64'(depth), 64'(2));
    req2(1'b0, '0, 1'b0, '0);
    wait_idle();
    chk("pop_depth", 64'(depth), 64'(0));

    // Overflow at capacity, then pop the top entry
    do_reset();
    t0 = trig_cnt;
    for (int i = 0; i < 5; i++) begin
      req(0, 1'b1, WIDTH'(32'hA0 + i));
      wait_idle();
    end
    chk("ovf_trigs", 64'(trig_cnt - t0), 64'(4));
    req(0, 1'b0, '0);
    wait_idle();
    chk("ovf_rdata", 64'(req0_rdata), 64'(32'hA3));
    chk("ovf_depth", 64'(depth), 64'(3));

    // Reset while waiting on memory; late completion is ignored
    do_reset();
    mem_on = 1'b0;
    req(0, 1'b1, 32'h77);
    tick();
    tick();
    do_reset();
    chk("mid_out", 64'({req0_done, req1_done, req0_err, req1_err,
                        stk_trigger, stk_push, stk_wdata}), 64'(0));
    stk_rdata = 32'h99;
    stk_done  = 1'b1;
    tick();
    repeat (5) tick();
    chk("mid_depth", 64'(depth), 64'(0));
    chk("mid_rdata", {req0_rdata, req1_rdata}, 64'(0));
    mem_on = 1'b1;
    mem.delete();
    req(0, 1'b1, 32'h78);
    wait_idle();
    chk("mid_after", 64'(depth), 64'(1));

`ifdef STACK_ARB_TIMEOUT_EN
    // Memory never answers: timeout error after TIMEOUT wait cycles
    do_reset();
    mem_on  = 1'b0;
    to_mode = 1'b1;
    req(0, 1'b1, 32'h55);
    to_mode = 1'b0;
    wait_idle();
    chk("to_lat", 64'(done_cyc[0] - trig_cyc), 64'(TIMEOUT));
    chk("to_depth", 64'(depth), 64'(0));
    mem.delete();
    stk_rdata = 32'h12;
    stk_done  = 1'b1;
    tick();
    repeat (3) tick();
    mem_on = 1'b1;
    req(0, 1'b1, 32'h66);
    wait_idle();
    chk("to_next", 64'(depth), 64'(1));
`endif

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
